// File: rtl/ifetch_unit.sv
// Sequential instruction fetcher: issues word reads to a 1-cycle memory and buffers {pc,instr} pairs.
// Optional IFETCH_STATS_EN adds push/flush event counters.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0] stat_fetch_cnt,
    output logic [31:0] stat_flush_cnt
`endif
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   issued_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   pc_q  [FIFO_DEPTH];
    logic [31:0]   ins_q [FIFO_DEPTH];
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW-1:0] occ;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready & ~redirect;
    assign push        = inflight & ~redirect;
    // Count the outstanding read as occupied so a full FIFO can never be overrun.
    assign occ         = count + CW'(inflight) - CW'(pop);
    assign issue       = resetn & ~redirect & (occ < DEPTH_C);
    assign mem_rstrb   = issue;
    assign mem_addr    = fetch_pc;
    assign instr       = instr_valid ? ins_q[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_q[rd_ptr]  : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= '0;
            inflight  <= 1'b0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else if (redirect) begin
            // Any response arriving this cycle belongs to the old stream and is dropped.
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                issued_pc <= fetch_pc;
                fetch_pc  <= fetch_pc + 32'd4;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]  <= issued_pc;
            ins_q[wr_ptr] <= mem_rdata;
        end
    end

`ifdef IFETCH_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_fetch_cnt <= '0;
            stat_flush_cnt <= '0;
        end else begin
            if (push)     stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
            if (redirect) stat_flush_cnt <= stat_flush_cnt + 32'd1;
        end
    end
`endif
endmodule
